// File: rtl/wb_counter_pkg.sv
// Shared definitions for the Wishbone up/down counter peripheral:
// register offsets, CTRL/STATUS bit positions, bus FSM states and a
// byte-lane mask helper.
package wb_counter_pkg;

  localparam logic [3:0] CTRL_OFS     = 4'h0;
  localparam logic [3:0] COUNT_OFS    = 4'h4;
  localparam logic [3:0] PRESCALE_OFS = 4'h8;
  localparam logic [3:0] STATUS_OFS   = 4'hC;

  localparam int unsigned EN_BIT     = 0;
  localparam int unsigned UP_BIT     = 1;
  localparam int unsigned IRQ_EN_BIT = 2;
  localparam int unsigned CTRL_BITS  = 3;
  localparam int unsigned WRAP_BIT   = 0;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    HOLD
  } bus_state_t;

  // Expand the four byte-lane enables into a 32-bit bit mask.
  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      m[i*8 +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/updown_counter_core.sv
// Prescaled up/down counter with wrap detection.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   en, up          count enable and direction (1 = increment)
//   prescale        counter steps once every prescale+1 enabled cycles
//   load            load count from load_val under load_mask (wins over a tick)
//   load_val/mask   value and per-bit mask for the load
//   ps_clr          clear the prescaler (prescale register written)
//   count           registered counter value
//   wrap_pulse      high in the cycle whose tick wraps the counter
module updown_counter_core #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned PS_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 up,
  input  logic [PS_WIDTH-1:0]  prescale,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic [CNT_WIDTH-1:0] load_mask,
  input  logic                 ps_clr,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 wrap_pulse
);

  logic [PS_WIDTH-1:0]  r_ps_cnt;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 w_tick;
  logic                 w_at_limit;

  assign w_tick     = en && (r_ps_cnt == prescale);
  assign w_at_limit = up ? (r_count == '1) : (r_count == '0);
  // A load on the tick edge discards the tick, so it cannot wrap either.
  assign wrap_pulse = w_tick && !load && w_at_limit;
  assign count      = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ps_cnt <= '0;
    end else if (!en || load || ps_clr || w_tick) begin
      r_ps_cnt <= '0;
    end else begin
      r_ps_cnt <= r_ps_cnt + PS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= (r_count & ~load_mask) | (load_val & load_mask);
    end else if (w_tick) begin
      r_count <= up ? (r_count + CNT_WIDTH'(1)) : (r_count - CNT_WIDTH'(1));
    end
  end

endmodule

// File: rtl/wb_counter_slave.sv
// Wishbone classic single-beat slave for the up/down counter peripheral.
// Registers: 0x0 CTRL (EN, UP, IRQ_EN), 0x4 COUNT, 0x8 PRESCALE,
// 0xC STATUS (WRAP, write-1-to-clear). Addresses above 0xF get an error.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   wb_cyc_i, wb_stb_i       request qualifiers
//   wb_we_i, wb_sel_i        write enable, byte lanes (writes only)
//   wb_adr_i, wb_dat_i       byte address, write data
//   wb_dat_o                 registered read data, valid with wb_ack_o
//   wb_ack_o, wb_err_o       one-cycle acknowledge / error
//   count_o                  live counter value
//   irq_o                    STATUS.WRAP & CTRL.IRQ_EN
module wb_counter_slave
  import wb_counter_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned PS_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [3:0]           wb_sel_i,
  input  logic [31:0]          wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 irq_o
);

  bus_state_t r_state;
  bus_state_t w_next_state;

  logic [CTRL_BITS-1:0] r_ctrl;
  logic [PS_WIDTH-1:0]  r_prescale;
  logic                 r_wrap;
  logic                 r_ack;
  logic                 r_err;
  logic [31:0]          r_dat;

  logic                 w_req;
  logic                 w_accept;
  logic                 w_addr_err;
  logic                 w_wr;
  logic                 w_rd;
  logic [3:0]           w_reg_ofs;
  logic [31:0]          w_lane_mask;
  logic                 w_wr_ctrl;
  logic                 w_wr_count;
  logic                 w_wr_ps;
  logic                 w_wr_status;
  logic                 w_w1c_wrap;
  logic [31:0]          w_rd_data;
  logic [CNT_WIDTH-1:0] w_count;
  logic                 w_wrap_pulse;
  logic                 w_unused;

  assign w_req       = wb_cyc_i && wb_stb_i;
  assign w_accept    = (r_state == IDLE) && w_req;
  assign w_addr_err  = |wb_adr_i[31:4];
  assign w_reg_ofs   = {wb_adr_i[3:2], 2'b00};
  assign w_lane_mask = sel_to_mask(wb_sel_i);
  assign w_wr        = w_accept && wb_we_i && !w_addr_err;
  assign w_rd        = w_accept && !wb_we_i && !w_addr_err;
  assign w_wr_ctrl   = w_wr && (w_reg_ofs == CTRL_OFS);
  assign w_wr_count  = w_wr && (w_reg_ofs == COUNT_OFS);
  assign w_wr_ps     = w_wr && (w_reg_ofs == PRESCALE_OFS);
  assign w_wr_status = w_wr && (w_reg_ofs == STATUS_OFS);
  assign w_w1c_wrap  = w_wr_status && wb_dat_i[WRAP_BIT] && w_lane_mask[WRAP_BIT];

  assign w_unused = &{1'b0, wb_adr_i[1:0], wb_dat_i, w_lane_mask};

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_req) w_next_state = RESP;
      RESP:    w_next_state = HOLD;
      HOLD:    if (!w_req) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (w_reg_ofs)
      CTRL_OFS:     w_rd_data[CTRL_BITS-1:0] = r_ctrl;
      COUNT_OFS:    w_rd_data[CNT_WIDTH-1:0] = w_count;
      PRESCALE_OFS: w_rd_data[PS_WIDTH-1:0]  = r_prescale;
      STATUS_OFS:   w_rd_data[WRAP_BIT]      = r_wrap;
      default:      w_rd_data = '0;
    endcase
  end

  // Response, read data and writes all commit on the edge that accepts
  // the request, so ack/err are high exactly while the FSM sits in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl     <= '0;
      r_prescale <= '0;
      r_wrap     <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_dat      <= '0;
    end else begin
      r_ack <= w_accept && !w_addr_err;
      r_err <= w_accept && w_addr_err;
      r_dat <= w_rd ? w_rd_data : '0;
      if (w_wr_ctrl) begin
        r_ctrl <= (r_ctrl & ~w_lane_mask[CTRL_BITS-1:0])
                | (wb_dat_i[CTRL_BITS-1:0] & w_lane_mask[CTRL_BITS-1:0]);
      end
      if (w_wr_ps) begin
        r_prescale <= (r_prescale & ~w_lane_mask[PS_WIDTH-1:0])
                    | (wb_dat_i[PS_WIDTH-1:0] & w_lane_mask[PS_WIDTH-1:0]);
      end
      // A wrap on the same edge as a clear must leave WRAP set.
      if (w_wrap_pulse) begin
        r_wrap <= 1'b1;
      end else if (w_w1c_wrap) begin
        r_wrap <= 1'b0;
      end
    end
  end

  updown_counter_core #(
    .CNT_WIDTH(CNT_WIDTH),
    .PS_WIDTH (PS_WIDTH)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .en        (r_ctrl[EN_BIT]),
    .up        (r_ctrl[UP_BIT]),
    .prescale  (r_prescale),
    .load      (w_wr_count),
    .load_val  (wb_dat_i[CNT_WIDTH-1:0]),
    .load_mask (w_lane_mask[CNT_WIDTH-1:0]),
    .ps_clr    (w_wr_ps),
    .count     (w_count),
    .wrap_pulse(w_wrap_pulse)
  );

  assign wb_dat_o = r_dat;
  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign count_o  = w_count;
  assign irq_o    = r_wrap && r_ctrl[IRQ_EN_BIT];

endmodule
